// File: rtl/br_pkg.sv
// Shared constants for the branch resolution controller: compare codes,
// FSM state encodings and BHT counter saturation limits.
package br_pkg;

  // Compare codes presented on BrCtrl
  localparam logic [2:0] BR_LTZ = 3'd1;
  localparam logic [2:0] BR_GEZ = 3'd2;
  localparam logic [2:0] BR_EQ  = 3'd4;
  localparam logic [2:0] BR_NEQ = 3'd5;

  // Controller states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RESOLVE  = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  // 2-bit saturating counter limits
  localparam logic [1:0] CNT_MAX = 2'd3;
  localparam logic [1:0] CNT_MIN = 2'd0;

  function automatic logic br_legal(input logic [2:0] code);
    case (code)
      BR_LTZ, BR_GEZ, BR_EQ, BR_NEQ: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2**IDX_W two-bit saturating counters with one
// combinational read port and one synchronous update port. The read port
// sees the pre-update value when both ports address the same entry.
module bht_table
  import br_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int N = 1 << IDX_W;

  logic [1:0] cnt_q [N];
  logic [1:0] cnt_d [N];

  assign rd_cnt = cnt_q[rd_idx];

  // Only the addressed counter moves, saturating at both ends
  always_comb begin
    for (int i = 0; i < N; i++) cnt_d[i] = cnt_q[i];
    if (upd_en) begin
      if (upd_taken) begin
        if (cnt_q[upd_idx] != CNT_MAX) cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
      end else begin
        if (cnt_q[upd_idx] != CNT_MIN) cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
      end
    end
  end

  // Counter storage, all entries forced to CNT_INIT on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= CNT_INIT;
    end else begin
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: accepts a branch from ID, resolves its
// compare one cycle later, trains the BHT and raises redirect/flush on a
// mispredict.
//
//   state    | meaning
//   IDLE     | no branch in flight, ready to accept
//   RESOLVE  | latched branch is evaluated this cycle (ResValid pulse)
//   REDIRECT | remaining flush cycles after a mispredict, not accepting
module branch_resolve_ctrl
  import br_pkg::*;
#(
  parameter int         BHT_IDX_W    = 6,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [1:0] CNT_INIT     = 2'b01
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] PredPC,
  output logic        PredTaken,
  input  logic        BrValid,
  output logic        BrReady,
  input  logic [2:0]  BrCtrl,
  input  logic [31:0] BrA,
  input  logic [31:0] BrB,
  input  logic [31:0] BrPC,
  input  logic [31:0] BrTarget,
  input  logic        BrPredTaken,
  output logic        ResValid,
  output logic        ResTaken,
  output logic        ResMispredict,
  output logic        ResIllegal,
  output logic [31:0] RedirectPC,
  output logic        Flush
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [31:0]      a_q, a_d, b_q, b_d, pc_q, pc_d, tgt_q, tgt_d;
  logic             pred_q, pred_d;
  logic             hold_taken_q, hold_taken_d;
  logic [31:0]      hold_redir_q, hold_redir_d;

  logic        in_resolve, legal, cmp_true, taken_now, mispredict, xfer;
  logic [31:0] redir_now;
  logic [1:0]  pred_cnt;
  logic        unused_sink;

  // Evaluate the latched branch; illegal codes never count as taken
  always_comb begin
    cmp_true = 1'b0;
    legal    = br_legal(ctrl_q);
    case (ctrl_q)
      BR_LTZ:  cmp_true = a_q[31];
      BR_GEZ:  cmp_true = ~a_q[31];
      BR_EQ:   cmp_true = (a_q == b_q);
      BR_NEQ:  cmp_true = (a_q != b_q);
      default: cmp_true = 1'b0;
    endcase
    in_resolve = (state_q == ST_RESOLVE);
    taken_now  = legal & cmp_true;
    mispredict = in_resolve & legal & (taken_now != pred_q);
    redir_now  = taken_now ? tgt_q : (pc_q + 32'd4);
  end

  assign BrReady = (state_q == ST_IDLE) | (in_resolve & ~mispredict);
  assign xfer    = BrValid & BrReady;
  assign Flush   = mispredict | (state_q == ST_REDIRECT);

  assign ResValid      = in_resolve;
  assign ResTaken      = in_resolve ? taken_now : hold_taken_q;
  assign RedirectPC    = in_resolve ? redir_now : hold_redir_q;
  assign ResMispredict = mispredict;
  assign ResIllegal    = in_resolve & ~legal;

  // Next state and flush countdown
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (mispredict) begin
          if (FLUSH_CYCLES == 1) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_REDIRECT;
            flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
          end
        end else if (xfer) begin
          state_d = ST_RESOLVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (flush_cnt_q <= CNT_W'(1)) begin
          flush_cnt_d = '0;
          state_d     = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch on transfer; resolution result held between resolves
  always_comb begin
    ctrl_d       = ctrl_q;
    a_d          = a_q;
    b_d          = b_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    pred_d       = pred_q;
    hold_taken_d = hold_taken_q;
    hold_redir_d = hold_redir_q;
    if (xfer) begin
      ctrl_d = BrCtrl;
      a_d    = BrA;
      b_d    = BrB;
      pc_d   = BrPC;
      tgt_d  = BrTarget;
      pred_d = BrPredTaken;
    end
    if (in_resolve) begin
      hold_taken_d = taken_now;
      hold_redir_d = redir_now;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= '0;
      ctrl_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      pc_q         <= '0;
      tgt_q        <= '0;
      pred_q       <= 1'b0;
      hold_taken_q <= 1'b0;
      hold_redir_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      ctrl_q       <= ctrl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      pred_q       <= pred_d;
      hold_taken_q <= hold_taken_d;
      hold_redir_q <= hold_redir_d;
    end
  end

  bht_table #(
    .IDX_W    (BHT_IDX_W),
    .CNT_INIT (CNT_INIT)
  ) u_bht (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .rd_idx    (PredPC[BHT_IDX_W+1:2]),
    .rd_cnt    (pred_cnt),
    .upd_en    (in_resolve & legal),
    .upd_idx   (pc_q[BHT_IDX_W+1:2]),
    .upd_taken (taken_now)
  );

  assign PredTaken = pred_cnt[1];

  // PC bits outside the index and the counter LSB do not affect prediction
  assign unused_sink = ^{PredPC[31:BHT_IDX_W+2], PredPC[1:0], pred_cnt[0]};

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized self-checking bench for branch_resolve_ctrl with a
// transaction-level reference model (pending branch, flush cycles left,
// counter array) plus directed scenarios with literal expectations.
module tb_branch_resolve_ctrl;

  localparam int         IDX_W = 6;
  localparam int         FC    = 2;
  localparam logic [1:0] CINIT = 2'b01;

  logic        Clk, Rst_n, BrValid, BrPredTaken;
  logic [31:0] PredPC, BrA, BrB, BrPC, BrTarget;
  logic [2:0]  BrCtrl;
  logic        PredTaken, BrReady, ResValid, ResTaken, ResMispredict, ResIllegal, Flush;
  logic [31:0] RedirectPC;

  branch_resolve_ctrl #(.BHT_IDX_W(IDX_W), .FLUSH_CYCLES(FC), .CNT_INIT(CINIT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .PredPC(PredPC), .PredTaken(PredTaken),
    .BrValid(BrValid), .BrReady(BrReady), .BrCtrl(BrCtrl), .BrA(BrA), .BrB(BrB),
    .BrPC(BrPC), .BrTarget(BrTarget), .BrPredTaken(BrPredTaken),
    .ResValid(ResValid), .ResTaken(ResTaken), .ResMispredict(ResMispredict),
    .ResIllegal(ResIllegal), .RedirectPC(RedirectPC), .Flush(Flush)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_known = 0;
  logic [1:0]  m_bht [1 << IDX_W];
  bit          m_pend;
  logic [2:0]  m_ctrl;
  logic [31:0] m_a, m_b, m_pc, m_tgt;
  bit          m_pred;
  int          m_flush_left;
  bit          m_hold_taken;
  logic [31:0] m_hold_redir;
  bit          e_legal, e_taken, e_mis, e_flush, e_ready;
  logic [31:0] e_redir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic model_eval();
    e_legal = (m_ctrl == 3'd1) || (m_ctrl == 3'd2) || (m_ctrl == 3'd4) || (m_ctrl == 3'd5);
    case (m_ctrl)
      3'd1:    e_taken = ($signed(m_a) < 0);
      3'd2:    e_taken = ($signed(m_a) >= 0);
      3'd4:    e_taken = (m_a == m_b);
      3'd5:    e_taken = (m_a != m_b);
      default: e_taken = 1'b0;
    endcase
    e_mis   = m_pend && e_legal && (e_taken != m_pred);
    e_flush = e_mis || (m_flush_left > 0);
    e_ready = !e_flush;
    e_redir = e_taken ? m_tgt : m_pc + 32'd4;
  endtask

  task automatic model_compare();
    if (!m_known) return;
    chk("PredTaken", 32'(PredTaken), 32'(m_bht[PredPC[IDX_W+1:2]][1]));
    chk("BrReady", 32'(BrReady), 32'(e_ready));
    chk("Flush", 32'(Flush), 32'(e_flush));
    chk("ResValid", 32'(ResValid), 32'(m_pend));
    chk("ResTaken", 32'(ResTaken), 32'(m_pend ? e_taken : m_hold_taken));
    chk("RedirectPC", RedirectPC, m_pend ? e_redir : m_hold_redir);
    if (m_pend) begin
      chk("ResMispredict", 32'(ResMispredict), 32'(e_mis));
      chk("ResIllegal", 32'(ResIllegal), 32'(!e_legal));
    end
  endtask

  task automatic model_update();
    int idx;
    if (!Rst_n) begin
      m_known = 1;
      for (int i = 0; i < (1 << IDX_W); i++) m_bht[i] = CINIT;
      m_pend = 0; m_flush_left = 0; m_hold_taken = 0; m_hold_redir = '0;
      m_ctrl = '0; m_a = '0; m_b = '0; m_pc = '0; m_tgt = '0; m_pred = 0;
      return;
    end
    if (m_pend) begin
      m_hold_taken = e_taken;
      m_hold_redir = e_redir;
      if (e_legal) begin
        idx = int'(m_pc[IDX_W+1:2]);
        if (e_taken && m_bht[idx] < 2'd3) m_bht[idx] = m_bht[idx] + 2'd1;
        if (!e_taken && m_bht[idx] > 2'd0) m_bht[idx] = m_bht[idx] - 2'd1;
      end
    end
    if (e_mis) m_flush_left = FC - 1;
    else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
    if (BrValid && e_ready) begin
      m_pend = 1; m_ctrl = BrCtrl; m_a = BrA; m_b = BrB;
      m_pc = BrPC; m_tgt = BrTarget; m_pred = BrPredTaken;
    end else begin
      m_pend = 0;
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic p, input logic [31:0] ppc);
    @(negedge Clk);
    Rst_n = rst; BrValid = v; BrCtrl = c; BrA = a; BrB = b;
    BrPC = pc; BrTarget = tgt; BrPredTaken = p; PredPC = ppc;
    #1;
    model_eval();
    model_compare();
  endtask

  task automatic commit();
    @(posedge Clk);
    model_update();
  endtask

  task automatic idle(input logic [31:0] ppc);
    drive(1, 0, 3'd0, 0, 0, 0, 0, 0, ppc);
  endtask

  initial begin
    logic [2:0]  rc;
    logic [31:0] ra, rb, rpc;
    Rst_n = 0; BrValid = 0; BrCtrl = 0; BrA = 0; BrB = 0;
    BrPC = 0; BrTarget = 0; BrPredTaken = 0; PredPC = 0;

    // Reset for two cycles
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0); commit();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0); commit();
    idle(32'h0000_0abc);
    chk("rst_ready", 32'(BrReady), 32'd1);
    chk("rst_flush", 32'(Flush), 32'd0);
    chk("rst_valid", 32'(ResValid), 32'd0);
    chk("rst_pred", 32'(PredTaken), 32'd0);
    chk("rst_redir", RedirectPC, 32'd0);
    commit();

    // EQ taken, correctly predicted
    drive(1, 1, 3'd4, 5, 5, 32'h100, 32'h200, 1, 32'h100);
    chk("eq_ready", 32'(BrReady), 32'd1);
    commit();
    idle(32'h100);
    chk("eq_valid", 32'(ResValid), 32'd1);
    chk("eq_taken", 32'(ResTaken), 32'd1);
    chk("eq_mis", 32'(ResMispredict), 32'd0);
    chk("eq_redir", RedirectPC, 32'h200);
    chk("eq_flush", 32'(Flush), 32'd0);
    chk("eq_pred_preupd", 32'(PredTaken), 32'd0);
    commit();
    idle(32'h100);
    chk("eq_pred_post", 32'(PredTaken), 32'd1);
    chk("eq_redir_hold", RedirectPC, 32'h200);
    commit();

    // LTZ taken, predicted not-taken: mispredict and two-cycle flush
    drive(1, 1, 3'd1, 32'hFFFF_FFFF, 0, 32'h300, 32'h400, 0, 0); commit();
    drive(1, 1, 3'd2, 1, 0, 32'h500, 32'h600, 1, 0);
    chk("ltz_mis", 32'(ResMispredict), 32'd1);
    chk("ltz_flush1", 32'(Flush), 32'd1);
    chk("ltz_ready1", 32'(BrReady), 32'd0);
    chk("ltz_redir", RedirectPC, 32'h400);
    commit();
    drive(1, 1, 3'd2, 1, 0, 32'h500, 32'h600, 1, 0);
    chk("ltz_flush2", 32'(Flush), 32'd1);
    chk("ltz_ready2", 32'(BrReady), 32'd0);
    chk("ltz_redir_hold", RedirectPC, 32'h400);
    commit();
    drive(1, 1, 3'd2, 1, 0, 32'h500, 32'h600, 1, 0);
    chk("ltz_flush_end", 32'(Flush), 32'd0);
    chk("ltz_ready_end", 32'(BrReady), 32'd1);
    chk("ltz_not_accepted", 32'(ResValid), 32'd0);
    commit();
    idle(0);
    chk("gez_valid", 32'(ResValid), 32'd1);
    chk("gez_redir", RedirectPC, 32'h600);
    commit();

    // Four back-to-back NEQ taken at 0x40, then one not-taken
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 3'd5, 1, 2, 32'h40, 32'h80, 1, 32'h40);
      chk("neq_ready", 32'(BrReady), 32'd1);
      if (i > 0) chk("neq_valid", 32'(ResValid), 32'd1);
      commit();
    end
    drive(1, 1, 3'd5, 7, 7, 32'h40, 32'h80, 0, 32'h40);
    chk("neq_pred_sat", 32'(PredTaken), 32'd1);
    chk("neq_ready5", 32'(BrReady), 32'd1);
    commit();
    idle(32'h40);
    chk("neq_nt_redir", RedirectPC, 32'h44);
    chk("neq_nt_flush", 32'(Flush), 32'd0);
    commit();
    idle(32'h40);
    chk("neq_pred_after_dec", 32'(PredTaken), 32'd1);
    commit();

    // Illegal code at 0x100 (entry currently weakly taken)
    drive(1, 1, 3'd0, 3, 3, 32'h100, 32'h900, 1, 32'h100); commit();
    idle(32'h100);
    chk("ill_flag", 32'(ResIllegal), 32'd1);
    chk("ill_taken", 32'(ResTaken), 32'd0);
    chk("ill_mis", 32'(ResMispredict), 32'd0);
    chk("ill_flush", 32'(Flush), 32'd0);
    chk("ill_redir", RedirectPC, 32'h104);
    commit();
    idle(32'h100);
    chk("ill_bht_unchanged", 32'(PredTaken), 32'd1);
    commit();

    // Not-taken at the top of the address space wraps to 0
    drive(1, 1, 3'd2, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 32'h10, 0, 0); commit();
    idle(0);
    chk("wrap_redir", RedirectPC, 32'h0);
    commit();

    // Reset asserted in the first REDIRECT cycle
    drive(1, 1, 3'd4, 1, 2, 32'h700, 32'h800, 1, 0); commit();
    idle(0);
    chk("rr_flush_res", 32'(Flush), 32'd1);
    commit();
    drive(0, 1, 3'd4, 1, 1, 32'h700, 32'h800, 1, 0);
    chk("rr_flush_redir", 32'(Flush), 32'd1);
    commit();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h700);
    chk("rr_flush", 32'(Flush), 32'd0);
    chk("rr_ready", 32'(BrReady), 32'd1);
    chk("rr_valid", 32'(ResValid), 32'd0);
    chk("rr_pred", 32'(PredTaken), 32'd0);
    commit();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 2) rc = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 3))
          0: rc = 3'd1;
          1: rc = 3'd2;
          2: rc = 3'd4;
          default: rc = 3'd5;
        endcase
      end
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rpc = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_00FC);
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), rc, ra, rb, rpc,
            $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom & 32'h0000_00FF);
      commit();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
